led_scan_drv: RTL and testbench

//   Row-scanning LED matrix driver; consumer of the PWM counter. Latches pwm_cnt_i at frame start,

---
 rtl/led_scan_drv.sv | 129 ++++++++++++
 tb/tb_led_scan_drv.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_scan_drv.sv
// Row-scanning LED matrix driver: loads one row of pixels into a column shadow,
// compares each against the PWM threshold latched at frame start, then shows the row.
module led_scan_drv #(
  parameter int ROWS      = 8,
  parameter int COLS      = 16,
  parameter int PWM_DEPTH = 8,
  parameter int ROW_HOLD  = 64,
  parameter int BLANK_CYC = 4,
  localparam int AW = $clog2(ROWS*COLS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [PWM_DEPTH-1:0] pwm_cnt_i,
  output logic                 pix_rd_o,
  output logic [AW-1:0]        pix_addr_o,
  input  logic [PWM_DEPTH-1:0] pix_data_i,
  output logic [ROWS-1:0]      row_o,
  output logic [COLS-1:0]      col_o,
  output logic                 frame_end_o,
  output logic                 busy_o
);

  localparam int MAX_A = (BLANK_CYC > COLS + 1) ? BLANK_CYC : COLS + 1;
  localparam int MAX_C = (MAX_A > ROW_HOLD) ? MAX_A : ROW_HOLD;
  localparam int CW    = $clog2(MAX_C + 1);
  localparam int RW    = $clog2(ROWS);

  typedef enum logic [1:0] {IDLE, BLANK, LOAD, SHOW} state_t;

  state_t               state_reg, state_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [RW-1:0]        row_reg, row_next;
  logic [PWM_DEPTH-1:0] thr_reg, thr_next;
  logic [COLS-1:0]      shadow_reg, shadow_next;
  logic                 frame_end_reg, frame_end_next;
  logic                 pix_gt;
  logic [AW-1:0]        col_idx;

  assign pix_gt = (pix_data_i > thr_reg);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      row_reg       <= '0;
      thr_reg       <= '0;
      shadow_reg    <= '0;
      frame_end_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      row_reg       <= row_next;
      thr_reg       <= thr_next;
      shadow_reg    <= shadow_next;
      frame_end_reg <= frame_end_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    row_next       = row_reg;
    thr_next       = thr_reg;
    shadow_next    = shadow_reg;
    frame_end_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (en_i) begin
          state_next = BLANK;
          cnt_next   = '0;
          row_next   = '0;
          thr_next   = pwm_cnt_i;
        end
      end
      BLANK: begin
        if (cnt_reg == CW'(BLANK_CYC - 1)) begin
          state_next = LOAD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      LOAD: begin
        // Read data arrives one cycle after its strobe, so column k lands on count k+1.
        for (int i = 0; i < COLS; i++) begin
          if (cnt_reg == CW'(i + 1)) shadow_next[i] = pix_gt;
        end
        if (cnt_reg == CW'(COLS)) begin
          state_next = SHOW;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      SHOW: begin
        if (cnt_reg == CW'(ROW_HOLD - 1)) begin
          cnt_next = '0;
          if (row_reg == RW'(ROWS - 1)) begin
            row_next       = '0;
            frame_end_next = 1'b1;
            if (en_i) begin
              state_next = BLANK;
              thr_next   = pwm_cnt_i;
            end else begin
              state_next = IDLE;
            end
          end else begin
            row_next   = row_reg + RW'(1);
            state_next = BLANK;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // On the final LOAD cycle the address stays on the last column.
  assign col_idx     = (cnt_reg >= CW'(COLS)) ? AW'(COLS - 1) : AW'(cnt_reg);
  assign pix_rd_o    = (state_reg == LOAD) && (cnt_reg < CW'(COLS));
  assign pix_addr_o  = (state_reg == LOAD) ? (AW'(row_reg) * AW'(COLS) + col_idx) : '0;
  assign row_o       = (state_reg == SHOW) ? (ROWS'(1) << row_reg) : '0;
  assign col_o       = (state_reg == SHOW) ? shadow_reg : '0;
  assign frame_end_o = frame_end_reg;
  assign busy_o      = (state_reg != IDLE);

endmodule

// File: tb/tb_led_scan_drv.sv
// Bench for led_scan_drv: per-cycle reference model of the frame timeline plus
// table-driven pattern vectors and hand-written reset/threshold/disable sequences.
module tb_led_scan_drv;

  localparam int R = 4, C = 4, P = 8, H = 8, B = 3;
  localparam int RP = B + C + 1 + H;
  localparam int FRAME = R * RP;
  localparam int AW = $clog2(R*C);

  logic          clk_i = 1'b0;
  logic          rst_i, en_i;
  logic [P-1:0]  pwm_cnt_i, pix_data_i;
  logic          pix_rd_o, frame_end_o, busy_o;
  logic [AW-1:0] pix_addr_o;
  logic [R-1:0]  row_o;
  logic [C-1:0]  col_o;

  led_scan_drv #(.ROWS(R), .COLS(C), .PWM_DEPTH(P), .ROW_HOLD(H), .BLANK_CYC(B)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .pwm_cnt_i(pwm_cnt_i),
    .pix_rd_o(pix_rd_o), .pix_addr_o(pix_addr_o), .pix_data_i(pix_data_i),
    .row_o(row_o), .col_o(col_o), .frame_end_o(frame_end_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0, n_err = 0;
  logic [P-1:0] mem [R*C];
  logic [C-1:0] cap [R];
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame buffer: one-cycle read latency, junk when not reading.
  always @(posedge clk_i) pix_data_i <= pix_rd_o ? mem[pix_addr_o] : 8'hA5;

  // Reference model: position within the frame as a plain cycle index.
  bit           m_active = 1'b0, m_fe = 1'b0;
  int           m_p = 0;
  logic [P-1:0] m_thr = '0;

  always @(posedge clk_i) begin
    if (rst_i) begin
      m_active = 1'b0; m_p = 0; m_fe = 1'b0; m_thr = '0;
    end else begin
      m_fe = 1'b0;
      if (!m_active) begin
        if (en_i) begin m_active = 1'b1; m_p = 0; m_thr = pwm_cnt_i; end
      end else if (m_p == FRAME - 1) begin
        m_fe = 1'b1;
        if (en_i) begin m_p = 0; m_thr = pwm_cnt_i; end
        else m_active = 1'b0;
      end else begin
        m_p++;
      end
    end
  end

  function automatic logic [C-1:0] model_cols(input int r, input logic [P-1:0] t);
    logic [C-1:0] res;
    for (int c = 0; c < C; c++) res[c] = (mem[r*C + c] > t);
    return res;
  endfunction

  always @(negedge clk_i) begin
    logic [R-1:0] e_row;
    logic [C-1:0] e_col;
    logic [AW-1:0] e_addr;
    logic e_rd;
    bit addr_chk;
    int r, q;
    if (chk_on && !rst_i) begin
      e_row = '0; e_col = '0; e_rd = 1'b0; e_addr = '0; addr_chk = 1'b0; r = 0; q = 0;
      if (m_active) begin
        r = m_p / RP;
        q = m_p % RP;
        if (q >= B + C + 1) begin
          e_row = R'(1) << r;
          e_col = model_cols(r, m_thr);
        end
        if (q >= B && q < B + C) begin
          e_rd = 1'b1; e_addr = AW'(r*C + q - B); addr_chk = 1'b1;
        end
        if (q == B + C) begin e_addr = AW'(r*C + C - 1); addr_chk = 1'b1; end
      end
      chk("busy", 32'(busy_o), 32'(m_active));
      chk("frame_end", 32'(frame_end_o), 32'(m_fe));
      chk("row_o", 32'(row_o), 32'(e_row));
      chk("col_o", 32'(col_o), 32'(e_col));
      chk("pix_rd", 32'(pix_rd_o), 32'(e_rd));
      if (addr_chk) chk("pix_addr", 32'(pix_addr_o), 32'(e_addr));
      if (e_row != '0) cap[r] = col_o;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk_i);
    #1;
  endtask

  task automatic clear_cap();
    for (int r = 0; r < R; r++) cap[r] = 'x;
  endtask

  task automatic wait_fe(input int bound, output int cyc);
    bit ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk_i);
      cyc++;
      if (frame_end_o) begin ok = 1'b1; break; end
    end
    chk("frame_end_seen", 32'(ok), 32'd1);
    #1;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 3*FRAME; i++) begin
      @(negedge clk_i);
      if (!busy_o) begin ok = 1'b1; break; end
    end
    chk("idle_reached", 32'(ok), 32'd1);
    #1;
  endtask

  task automatic load_pat(input int pat);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        case (pat)
          0: mem[r*C + c] = P'(16*r + 4*c);
          1: mem[r*C + c] = 8'hFF;
          2: mem[r*C + c] = ((r + c) % 2 != 0) ? 8'h80 : 8'h7F;
          default: mem[r*C + c] = P'($urandom);
        endcase
  endtask

  task automatic cmp_cap(input string nm, input logic [4*C-1:0] exp);
    for (int r = 0; r < R; r++)
      chk($sformatf("%s_row%0d", nm, r), 32'(cap[r]), 32'(exp[r*C +: C]));
  endtask

  typedef struct {
    int           pat;
    logic [P-1:0] pwm;
    logic [4*C-1:0] exp;   // row r expectation in bits [4r+3:4r]
  } vec_t;

  vec_t tbl [6];

  initial begin
    int n, k;
    bit ok;
    tbl[0] = '{0, 8'd20,  16'hFFC0};
    tbl[1] = '{1, 8'hFF,  16'h0000};
    tbl[2] = '{1, 8'hFE,  16'hFFFF};
    tbl[3] = '{0, 8'h00,  16'hFFFE};
    tbl[4] = '{0, 8'hFF,  16'h0000};
    tbl[5] = '{2, 8'h7F,  16'h5A5A};
    for (int i = 0; i < 6000; i++) begin end
    load_pat(0);
    clear_cap();
    rst_i = 1'b1; en_i = 1'b0; pwm_cnt_i = '0;

    // Reset state
    step(3);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_fe", 32'(frame_end_o), 32'd0);
    chk("rst_row", 32'(row_o), 32'd0);
    chk("rst_col", 32'(col_o), 32'd0);
    chk("rst_rd", 32'(pix_rd_o), 32'd0);
    rst_i = 1'b0;
    chk_on = 1'b1;
    step(2);
    $display("reset released, idle busy=%0b", busy_o);

    // Asynchronous reset in the middle of SHOW, then restart latency
    pwm_cnt_i = 8'd0; en_i = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 2*RP; i++) begin
      @(negedge clk_i);
      if (row_o != '0) begin ok = 1'b1; break; end
    end
    chk("t1_show_reached", 32'(ok), 32'd1);
    #1 rst_i = 1'b1;
    #1;
    chk("t1_row", 32'(row_o), 32'd0);
    chk("t1_col", 32'(col_o), 32'd0);
    chk("t1_busy", 32'(busy_o), 32'd0);
    chk("t1_fe", 32'(frame_end_o), 32'd0);
    step(1);
    rst_i = 1'b0;
    k = 0; ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      k++;
      if (pix_rd_o) begin ok = 1'b1; break; end
    end
    chk("t1_rd_latency", 32'(k), 32'(B + 1));
    chk("t1_first_addr", 32'(pix_addr_o), 32'd0);
    #1;
    $display("t1 reset mid-show, first read after %0d cycles", k);
    en_i = 1'b0;
    wait_idle();

    // Table vectors: one single-frame scan per record
    for (int v = 0; v < 6; v++) begin
      load_pat(tbl[v].pat);
      pwm_cnt_i = tbl[v].pwm;
      clear_cap();
      en_i = 1'b1;
      step(1);
      en_i = 1'b0;
      wait_fe(2*FRAME, n);
      step(1);
      chk($sformatf("vec%0d_idle", v), 32'(busy_o), 32'd0);
      cmp_cap($sformatf("vec%0d", v), tbl[v].exp);
      $display("vec %0d pat %0d pwm %02h cols %h%h%h%h", v, tbl[v].pat, tbl[v].pwm,
               cap[3], cap[2], cap[1], cap[0]);
    end

    // Mid-frame threshold change, frame period, and disable within a frame
    load_pat(0);
    pwm_cnt_i = 8'h00;
    clear_cap();
    en_i = 1'b1;
    step(RP + 2);
    pwm_cnt_i = 8'hFF;
    wait_fe(2*FRAME, n);
    cmp_cap("t5_frame1", 16'hFFFE);
    clear_cap();
    wait_fe(2*FRAME, n);
    chk("t4_period", 32'(n), 32'(FRAME));
    cmp_cap("t5_frame2", 16'h0000);
    $display("t4/t5 period %0d cycles, second frame cols %h%h%h%h", n, cap[3], cap[2], cap[1], cap[0]);
    clear_cap();
    step(2*RP + 2);
    en_i = 1'b0;
    wait_fe(2*FRAME, n);
    cmp_cap("t6_frame", 16'h0000);
    step(1);
    chk("t6_idle", 32'(busy_o), 32'd0);
    step(2*FRAME);
    chk("t6_still_idle", 32'(busy_o), 32'd0);
    $display("t6 disable mid-frame, frame ended after %0d cycles, busy=%0b", n, busy_o);

    // Randomized runs against the reference model
    for (int rnd = 0; rnd < 3; rnd++) begin
      en_i = 1'b0;
      wait_idle();
      load_pat(3);
      for (int i = 0; i < 300; i++) begin
        en_i = ($urandom_range(0, 31) != 0);
        if ($urandom_range(0, 7) == 0) pwm_cnt_i = P'($urandom);
        step(1);
      end
      $display("random round %0d done, %0d vectors so far", rnd, n_vec);
    end
    en_i = 1'b0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
